ir_fetch: RTL and testbench
===========================

Name: ir_fetch

Overview:
- Bus-side producer for the instruction register and decode stage.
- Issues an Avalon-style instruction read at the PC supplied by the control FSM and waits out `waitrequest`.
- Captures `readdata` into an internal IR register, with an optional byte-lane swap, and holds it stable as `instr_word` for field decode across the rest of the instruction's cycles.
- Flags misaligned fetches and bus timeouts.

Parameters:
- `BYTE_SWAP`, 1, when 1 reverse the byte lanes of `readdata` before capture (little-endian bus to MIPS word order).
- `MAX_WAIT`, 0, maximum cycles `waitrequest` may stay high before a timeout fault; 0 disables the timeout.
- `WAIT_W`, 8, width of the wait counter; `MAX_WAIT` must fit in `WAIT_W` bits.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `fetch_req`  in  1  single-cycle pulse from the control FSM requesting a fetch at `fetch_pc`.
- `fetch_pc`  in  32  byte address of the instruction; sampled only in the cycle `fetch_req` is high.
- `flush`  in  1  abandon any fetch in flight and invalidate the IR.
- `instr_ack`  in  1  decode/execute has consumed the current word.
- `address`  out  32  bus address.
- `read`  out  1  bus read strobe.
- `byteenable`  out  4  bus byte enables.
- `waitrequest`  in  1  bus stall.
- `readdata`  in  32  bus read data.
- `instr_word`  out  32  registered instruction word.
- `instr_valid`  out  1  `instr_word` holds a freshly fetched, unconsumed instruction.
- `fetch_busy`  out  1  a bus read is outstanding.
- `fetch_fault`  out  1  sticky error flag.
- `fault_code`  out  2  error cause: 00 none, 01 misaligned, 10 timeout.

Behaviour:
- Reset values: `address`=0, `read`=0, `byteenable`=0, `instr_word`=0, `instr_valid`=0, `fetch_busy`=0, `fetch_fault`=0, `fault_code`=00, wait counter=0, state=IDLE.
- `reset` has priority over every other input in all states. Asserting it mid-read drops `read` in the following cycle; no capture occurs.
- States: IDLE, READ, HOLD, FAULT.
- IDLE:
  - `fetch_req` with `fetch_pc[1:0]`=00 → READ. Next cycle `address`=`fetch_pc`, `read`=1, `byteenable`=4'b1111, `fetch_busy`=1, counter cleared.
  - `fetch_req` with `fetch_pc[1:0]`≠00 → FAULT, `fault_code`=01. No bus access is made.
- READ:
  - `address`, `read` and `byteenable` are held constant while `waitrequest`=1.
  - In the first cycle with `read`=1 and `waitrequest`=0, the word is accepted. On the next edge: `instr_word` ← `readdata` (byte-reversed if `BYTE_SWAP`), `instr_valid`=1, `read`=0, `byteenable`=0, `fetch_busy`=0, state → HOLD.
  - Minimum latency: `fetch_req` at cycle N → `read` at N+1 → `instr_valid` at N+2 when `waitrequest`=0 throughout.
  - Timeout: the counter increments each cycle `waitrequest`=1. If `MAX_WAIT`≠0 and the counter reaches `MAX_WAIT` with `waitrequest` still high, drop `read` → FAULT, `fault_code`=10.
- HOLD:
  - `instr_word` is held indefinitely.
  - `instr_ack` clears `instr_valid`; `instr_word` is unchanged → IDLE.
  - `fetch_req` is accepted directly (acts as an implicit ack) with the same checks as IDLE.
  - `fetch_req` and `instr_ack` in the same cycle: `fetch_req` wins; `instr_valid` falls as the new read begins.
- `flush`:
  - In READ: `read` drops next cycle, no capture, → IDLE.
  - In HOLD: `instr_valid`=0 → IDLE; `instr_word` is unchanged.
  - `flush` and `fetch_req` in the same cycle: `flush` wins and the request is ignored.
- FAULT:
  - `fetch_fault`=1 and `fault_code` are held. All inputs except `reset` are ignored; only `reset` exits.
- `fetch_req` arriving while in READ is a protocol violation. It is ignored, and an assertion in the bench flags it.
- `instr_word` never changes except on a successful capture or on reset.

Decomposition:
- Shared package `mips_bus_pkg` holds:
  - fetch-state enum `fetch_state_t`;
  - localparams `FAULT_NONE`, `FAULT_MISALIGN`, `FAULT_TIMEOUT`;
  - `BE_WORD`=4'b1111;
  - `RESET_VECTOR`=32'hBFC00000, used by the PC owner.
- One natural sub-module: `byte_swap32`, a combinational lane reverser, instantiated only when `BYTE_SWAP`=1.
- The wait counter and FSM stay inline.

Test Plan:
- Zero-wait fetch: `fetch_req`, `fetch_pc`=32'hBFC00000, `waitrequest`=0, `readdata`=32'h0800F024 → `read` high exactly one cycle at 32'hBFC00000; 2 cycles after `fetch_req`, `instr_word`=32'h24F00008 and `instr_valid`=1.
- Stalled bus: `waitrequest` high for 5 cycles, then low with `readdata`=32'h78563412 → `address`, `read` and `byteenable` stable for 6 cycles; `instr_word`=32'h12345678; no fault with `MAX_WAIT`=0.
- Misaligned: `fetch_pc`=32'hBFC00002 → `read` never asserted; `fetch_fault`=1, `fault_code`=01 next cycle; a later `fetch_req` is ignored until `reset`.
- Timeout: `MAX_WAIT`=4, `waitrequest` held high → `read` drops, `fault_code`=10; `instr_valid` stays 0.
- Flush and reset mid-read: `flush` during a stalled READ → `read`=0 next cycle and `instr_word` keeps its old value. Then `reset` during a second READ → all outputs return to their reset values on the next edge.
- HOLD contention: in HOLD assert `fetch_req` and `instr_ack` together at `fetch_pc`=32'h00000010 → new read is issued and `instr_valid` falls. With `BYTE_SWAP`=0 and `readdata`=32'hAABBCCDD → `instr_word`=32'hAABBCCDD.

Source files
------------

// File: rtl/mips_bus_pkg.sv
// Shared bus/fetch types and constants for the MIPS instruction path.
// Fault codes, the full-word byte enable and the boot PC live here.
package mips_bus_pkg;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    HOLD,
    FAULT
  } fetch_state_t;

  localparam logic [1:0] FAULT_NONE     = 2'b00;
  localparam logic [1:0] FAULT_MISALIGN = 2'b01;
  localparam logic [1:0] FAULT_TIMEOUT  = 2'b10;

  localparam logic [3:0] BE_WORD = 4'b1111;

  localparam logic [31:0] RESET_VECTOR = 32'hBFC00000;

endpackage

// File: rtl/byte_swap32.sv
// Combinational byte-lane reverser.
// Converts a little-endian bus word into MIPS big-endian word order.
module byte_swap32 (
  input  logic [31:0] d,
  output logic [31:0] q
);

  assign q = {d[7:0], d[15:8], d[23:16], d[31:24]};

endmodule

// File: rtl/ir_fetch.sv
// Instruction fetch: issues one Avalon read per request and holds the
// captured word in the IR until it is consumed, flushed or replaced.
module ir_fetch
  import mips_bus_pkg::*;
#(
  parameter bit          BYTE_SWAP = 1'b1,
  parameter int unsigned MAX_WAIT  = 0,
  parameter int unsigned WAIT_W    = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_req,
  input  logic [31:0] fetch_pc,
  input  logic        flush,
  input  logic        instr_ack,
  output logic [31:0] address,
  output logic        read,
  output logic [3:0]  byteenable,
  input  logic        waitrequest,
  input  logic [31:0] readdata,
  output logic [31:0] instr_word,
  output logic        instr_valid,
  output logic        fetch_busy,
  output logic        fetch_fault,
  output logic [1:0]  fault_code
);

  fetch_state_t st, st_n;

  logic [31:0]       addr_n;
  logic [31:0]       word_n;
  logic [31:0]       cap;
  logic              read_n;
  logic              valid_n;
  logic              busy_n;
  logic [3:0]        be_n;
  logic [1:0]        code_n;
  logic [WAIT_W-1:0] cnt, cnt_n;
  logic              timeout;

  generate
    if (BYTE_SWAP) begin : g_swap
      byte_swap32 u_swap (
        .d (readdata),
        .q (cap)
      );
    end else begin : g_noswap
      assign cap = readdata;
    end
  endgenerate

  assign timeout = (MAX_WAIT != 0) &&
                   (cnt == WAIT_W'(MAX_WAIT));

  assign fetch_fault = (st == FAULT);

  always_comb begin
    st_n    = st;
    addr_n  = address;
    read_n  = read;
    be_n    = byteenable;
    busy_n  = fetch_busy;
    word_n  = instr_word;
    valid_n = instr_valid;
    code_n  = fault_code;
    cnt_n   = cnt;
    unique case (st)
      IDLE, HOLD: begin
        if (flush) begin
          valid_n = 1'b0;
          st_n    = IDLE;
        end else if (fetch_req) begin
          // a new request also retires any word still held
          valid_n = 1'b0;
          if (fetch_pc[1:0] == 2'b00) begin
            st_n   = READ;
            addr_n = fetch_pc;
            read_n = 1'b1;
            be_n   = BE_WORD;
            busy_n = 1'b1;
            cnt_n  = '0;
          end else begin
            st_n   = FAULT;
            code_n = FAULT_MISALIGN;
          end
        end else if (instr_ack) begin
          valid_n = 1'b0;
          st_n    = IDLE;
        end
      end
      READ: begin
        if (flush || !waitrequest || timeout) begin
          read_n = 1'b0;
          be_n   = '0;
          busy_n = 1'b0;
        end
        if (flush) begin
          st_n = IDLE;
        end else if (!waitrequest) begin
          word_n  = cap;
          valid_n = 1'b1;
          st_n    = HOLD;
        end else if (timeout) begin
          st_n   = FAULT;
          code_n = FAULT_TIMEOUT;
        end else begin
          cnt_n = cnt + WAIT_W'(1);
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st          <= IDLE;
      address     <= '0;
      read        <= 1'b0;
      byteenable  <= '0;
      fetch_busy  <= 1'b0;
      instr_word  <= '0;
      instr_valid <= 1'b0;
      fault_code  <= FAULT_NONE;
      cnt         <= '0;
    end else begin
      st          <= st_n;
      address     <= addr_n;
      read        <= read_n;
      byteenable  <= be_n;
      fetch_busy  <= busy_n;
      instr_word  <= word_n;
      instr_valid <= valid_n;
      fault_code  <= code_n;
      cnt         <= cnt_n;
    end
  end

endmodule

// File: tb/tb_ir_fetch.sv
// Self-checking bench for ir_fetch: three instances (swap, swap+timeout,
// no-swap) driven from shared stimulus and a transaction-level model.
module tb_ir_fetch;

  logic        clk = 1'b0;
  logic        rst, rst1;
  logic        fetch_req, flush, instr_ack, waitrequest;
  logic [31:0] fetch_pc, readdata;

  logic [31:0] a0, w0, a1, w1, a2, w2;
  logic        r0, v0, b0, f0;
  logic        r1, v1, b1, f1;
  logic        r2, v2, b2, f2;
  logic [3:0]  be0, be1, be2;
  logic [1:0]  c0, c1, c2;

  int checks   = 0;
  int failures = 0;

  logic [31:0] exp0, exp2;

  always #5 clk = ~clk;

  ir_fetch #(.BYTE_SWAP(1'b1), .MAX_WAIT(0), .WAIT_W(8)) u0 (
    .clk(clk), .reset(rst), .fetch_req(fetch_req), .fetch_pc(fetch_pc),
    .flush(flush), .instr_ack(instr_ack), .address(a0), .read(r0),
    .byteenable(be0), .waitrequest(waitrequest), .readdata(readdata),
    .instr_word(w0), .instr_valid(v0), .fetch_busy(b0),
    .fetch_fault(f0), .fault_code(c0)
  );

  ir_fetch #(.BYTE_SWAP(1'b1), .MAX_WAIT(4), .WAIT_W(8)) u1 (
    .clk(clk), .reset(rst1), .fetch_req(fetch_req), .fetch_pc(fetch_pc),
    .flush(flush), .instr_ack(instr_ack), .address(a1), .read(r1),
    .byteenable(be1), .waitrequest(waitrequest), .readdata(readdata),
    .instr_word(w1), .instr_valid(v1), .fetch_busy(b1),
    .fetch_fault(f1), .fault_code(c1)
  );

  ir_fetch #(.BYTE_SWAP(1'b0), .MAX_WAIT(0), .WAIT_W(8)) u2 (
    .clk(clk), .reset(rst), .fetch_req(fetch_req), .fetch_pc(fetch_pc),
    .flush(flush), .instr_ack(instr_ack), .address(a2), .read(r2),
    .byteenable(be2), .waitrequest(waitrequest), .readdata(readdata),
    .instr_word(w2), .instr_valid(v2), .fetch_busy(b2),
    .fetch_fault(f2), .fault_code(c2)
  );

  // a request while a read is outstanding is a protocol violation
  always @(posedge clk) begin
    if (!rst) begin
      assert (!(fetch_req && r0))
        else $error("protocol: fetch_req while read outstanding");
    end
  end

  function automatic logic [31:0] lanes_rev(input logic [31:0] d);
    logic [31:0] q;
    q = '0;
    for (int i = 0; i < 4; i++)
      q = (q << 8) | ((d >> (8 * i)) & 32'hFF);
    return q;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; rst1 = 1'b1;
    fetch_req = 1'b0; flush = 1'b0; instr_ack = 1'b0;
    waitrequest = 1'b0; fetch_pc = '0; readdata = '0;
    repeat (2) step();
    rst = 1'b0;
    step();
    exp0 = '0; exp2 = '0;
  endtask

  task automatic fetch(input logic [31:0] pc, input logic [31:0] data,
                       input int stalls, input string tag);
    fetch_req = 1'b1; fetch_pc = pc; readdata = $urandom;
    step();
    fetch_req = 1'b0; fetch_pc = $urandom;
    for (int i = 0; i <= stalls; i++) begin
      checks++;
      if ({r0, a0, be0, b0, r2, a2, be2, b2} !==
          {1'b1, pc, 4'hF, 1'b1, 1'b1, pc, 4'hF, 1'b1}) begin
        failures++;
        $display("FAIL %s bus cycle %0d: read=%b/%b addr=%h/%h be=%h busy=%b required read=1 addr=%h be=f busy=1",
                 tag, i, r0, r2, a0, a2, be0, b0, pc);
      end
      if (i < stalls) begin
        waitrequest = 1'b1; readdata = $urandom;
      end else begin
        waitrequest = 1'b0; readdata = data;
      end
      step();
    end
    exp0 = lanes_rev(data);
    exp2 = data;
    checks++;
    if ({r0, be0, b0, v0, f0, c0, w0, r2, v2, w2} !==
        {1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 2'b00, exp0, 1'b0, 1'b1, exp2}) begin
      failures++;
      $display("FAIL %s capture: read=%b be=%h busy=%b valid=%b/%b fault=%b code=%b word=%h/%h required word=%h/%h valid=1",
               tag, r0, be0, b0, v0, v2, f0, c0, w0, w2, exp0, exp2);
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({a0, r0, be0, w0, v0, b0, f0, c0, a2, r2, w2, v2, f2} !== '0) begin
      failures++;
      $display("FAIL reset: addr=%h read=%b be=%h word=%h valid=%b busy=%b fault=%b code=%b required all zero",
               a0, r0, be0, w0, v0, b0, f0, c0);
    end
  endtask

  task automatic test_zero_wait();
    fetch(32'hBFC00000, 32'h0800F024, 0, "zero_wait");
    checks++;
    if (w0 !== 32'h24F00008) begin
      failures++;
      $display("FAIL zero_wait word: got %h required 24f00008", w0);
    end
  endtask

  task automatic test_stall();
    fetch(32'h00400000, 32'h78563412, 5, "stall");
    checks++;
    if (w0 !== 32'h12345678 || f0 !== 1'b0) begin
      failures++;
      $display("FAIL stall word: got %h fault=%b required 12345678 fault=0", w0, f0);
    end
  endtask

  task automatic test_hold();
    fetch(32'h00000020, $urandom, 0, "hold_pre");
    waitrequest = 1'b0;
    repeat (3) step();
    checks++;
    if ({v0, w0, v2, w2} !== {1'b1, exp0, 1'b1, exp2}) begin
      failures++;
      $display("FAIL hold keep: valid=%b word=%h required valid=1 word=%h", v0, w0, exp0);
    end
    instr_ack = 1'b1;
    step();
    instr_ack = 1'b0;
    checks++;
    if ({v0, w0, r0, v2, w2} !== {1'b0, exp0, 1'b0, 1'b0, exp2}) begin
      failures++;
      $display("FAIL hold ack: valid=%b word=%h read=%b required valid=0 word=%h read=0", v0, w0, r0, exp0);
    end
    fetch(32'h00000024, $urandom, 1, "hold_pre2");
    flush = 1'b1; fetch_req = 1'b1; fetch_pc = 32'h00000028;
    step();
    flush = 1'b0; fetch_req = 1'b0;
    step();
    checks++;
    if ({r0, v0, w0, r2, v2} !== {1'b0, 1'b0, exp0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL flush_vs_req: read=%b valid=%b word=%h required read=0 valid=0 word=%h", r0, v0, w0, exp0);
    end
    fetch(32'h0000002C, $urandom, 0, "hold_pre3");
    fetch_req = 1'b1; instr_ack = 1'b1; fetch_pc = 32'h00000010;
    waitrequest = 1'b0;
    step();
    fetch_req = 1'b0; instr_ack = 1'b0;
    checks++;
    if ({r0, a0, v0, r2, v2} !== {1'b1, 32'h00000010, 1'b0, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL contention issue: read=%b addr=%h valid=%b required read=1 addr=00000010 valid=0", r0, a0, v0);
    end
    readdata = 32'hAABBCCDD;
    step();
    exp2 = 32'hAABBCCDD;
    exp0 = lanes_rev(exp2);
    checks++;
    if ({w2, v2, w0, v0} !== {32'hAABBCCDD, 1'b1, exp0, 1'b1}) begin
      failures++;
      $display("FAIL contention capture: word=%h/%h valid=%b/%b required aabbccdd/%h", w2, w0, v2, v0, exp0);
    end
  endtask

  task automatic test_misaligned();
    fetch_req = 1'b1; fetch_pc = 32'hBFC00002;
    step();
    fetch_req = 1'b0;
    checks++;
    if ({r0, f0, c0, v0, w0, r2, f2, c2} !==
        {1'b0, 1'b1, 2'b01, 1'b0, exp0, 1'b0, 1'b1, 2'b01}) begin
      failures++;
      $display("FAIL misaligned: read=%b fault=%b code=%b valid=%b word=%h required read=0 fault=1 code=01 word=%h",
               r0, f0, c0, v0, w0, exp0);
    end
    for (int i = 0; i < 4; i++) begin
      fetch_req = 1'b1; fetch_pc = 32'h00001000; instr_ack = 1'b1;
      flush = (i == 2); waitrequest = 1'b0; readdata = $urandom;
      step();
      checks++;
      if ({r0, f0, c0, b0, w0, r2} !== {1'b0, 1'b1, 2'b01, 1'b0, exp0, 1'b0}) begin
        failures++;
        $display("FAIL fault sticky %0d: read=%b fault=%b code=%b word=%h required read=0 fault=1 code=01", i, r0, f0, c0, w0);
      end
    end
    fetch_req = 1'b0; instr_ack = 1'b0; flush = 1'b0;
    do_reset();
    checks++;
    if ({f0, c0, f2, c2} !== 6'b0) begin
      failures++;
      $display("FAIL fault clear: fault=%b code=%b required 0 00", f0, c0);
    end
  endtask

  task automatic test_timeout();
    int n;
    do_reset();
    rst1 = 1'b0;
    step();
    fetch_req = 1'b1; fetch_pc = 32'h00000100; waitrequest = 1'b1;
    step();
    fetch_req = 1'b0;
    n = 0;
    for (int i = 0; i < 12; i++) begin
      if (!r1) break;
      n++;
      step();
    end
    checks++;
    if (r1 !== 1'b0 || n < 4 || n > 6 || f1 !== 1'b1 || c1 !== 2'b10 || v1 !== 1'b0) begin
      failures++;
      $display("FAIL timeout: read=%b high_cycles=%0d fault=%b code=%b valid=%b required read=0 cycles 4..6 fault=1 code=10 valid=0",
               r1, n, f1, c1, v1);
    end
    waitrequest = 1'b0;
    repeat (3) step();
    checks++;
    if ({f1, c1, v1, w1, r1, b1} !== {1'b1, 2'b10, 1'b0, 32'h0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL timeout sticky: fault=%b code=%b valid=%b word=%h required 1 10 0 00000000", f1, c1, v1, w1);
    end
    do_reset();
  endtask

  task automatic test_flush_reset();
    logic [31:0] old0, old2;
    fetch(32'h00000040, $urandom, 1, "flush_pre");
    old0 = exp0; old2 = exp2;
    fetch_req = 1'b1; fetch_pc = 32'h00000044; waitrequest = 1'b1;
    step();
    fetch_req = 1'b0;
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    checks++;
    if ({r0, b0, v0, w0, r2, w2} !== {1'b0, 1'b0, 1'b0, old0, 1'b0, old2}) begin
      failures++;
      $display("FAIL flush: read=%b busy=%b valid=%b word=%h required read=0 busy=0 valid=0 word=%h", r0, b0, v0, w0, old0);
    end
    waitrequest = 1'b0; readdata = $urandom;
    step();
    checks++;
    if ({v0, w0, w2} !== {1'b0, old0, old2}) begin
      failures++;
      $display("FAIL flush no capture: valid=%b word=%h required valid=0 word=%h", v0, w0, old0);
    end
    fetch_req = 1'b1; fetch_pc = 32'h00000048; waitrequest = 1'b1;
    step();
    fetch_req = 1'b0;
    step();
    checks++;
    if (r0 !== 1'b1 || a0 !== 32'h00000048) begin
      failures++;
      $display("FAIL second read: read=%b addr=%h required 1 00000048", r0, a0);
    end
    rst = 1'b1; waitrequest = 1'b0;
    step();
    rst = 1'b0;
    exp0 = '0; exp2 = '0;
    test_reset();
  endtask

  task automatic test_random();
    logic [31:0] pc;
    for (int k = 0; k < 30; k++) begin
      pc = $urandom;
      pc[1:0] = 2'b00;
      fetch(pc, $urandom, int'($urandom_range(0, 4)), "random");
      if ($urandom_range(0, 1) == 1) begin
        instr_ack = 1'b1;
        step();
        instr_ack = 1'b0;
        checks++;
        if ({v0, w0, v2, w2} !== {1'b0, exp0, 1'b0, exp2}) begin
          failures++;
          $display("FAIL random ack %0d: valid=%b word=%h/%h required valid=0 word=%h/%h", k, v0, w0, w2, exp0, exp2);
        end
      end
      repeat ($urandom_range(0, 2)) step();
    end
  endtask

  initial begin
    do_reset();
    test_reset();
    test_zero_wait();
    test_stall();
    test_hold();
    test_misaligned();
    test_timeout();
    test_flush_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
